multi_channel_rr_arbiter: RTL

MULTI_CHANNEL_RR_ARBITER -- requirements
Module: multi_channel_rr_arbiter

---
 rtl/multi_channel_rr_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_rr_arbiter.sv
// multi_channel_rr_arbiter
// Shares NUM_CHANNELS optical channels among NUM_ROUTERS requesting routers.
// Each channel is IDLE, OFFERED or BUSY. While no offer is outstanding, the
// lowest-indexed IDLE channel is offered for one cycle to the first eligible
// router found by scanning upward from a round-robin pointer. The offered
// router accepts by keeping its request high at the end of that cycle. The
// owner frees the channel with done, or an optional busy timeout frees it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   request    : per-router channel request (level)
//   done       : per-router transfer-complete pulse
//   grant      : registered one-hot offer (zero when no offer)
//   grant_chan : index of the offered channel, valid while grant != 0
//   chan_busy  : per-channel BUSY flag
//   chan_owner : per-channel owner index, slice c = [c*RW +: RW], 0 unless BUSY
//   timeout    : per-channel one-cycle pulse on forced release
module multi_channel_rr_arbiter #(
  parameter int NUM_ROUTERS    = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int RW = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ROUTERS-1:0]       request,
  input  logic [NUM_ROUTERS-1:0]       done,
  output logic [NUM_ROUTERS-1:0]       grant,
  output logic [CW-1:0]                grant_chan,
  output logic [NUM_CHANNELS-1:0]      chan_busy,
  output logic [NUM_CHANNELS*RW-1:0]   chan_owner,
  output logic [NUM_CHANNELS-1:0]      timeout
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {CH_IDLE, CH_OFFERED, CH_BUSY} chan_state_e;

  chan_state_e             state_q [NUM_CHANNELS];
  chan_state_e             state_d [NUM_CHANNELS];
  // While OFFERED, owner holds the offered router so the accept can be resolved.
  logic [RW-1:0]           owner_q [NUM_CHANNELS];
  logic [RW-1:0]           owner_d [NUM_CHANNELS];
  logic [TW-1:0]           cnt_q   [NUM_CHANNELS];
  logic [TW-1:0]           cnt_d   [NUM_CHANNELS];
  logic [NUM_ROUTERS-1:0]  grant_q, grant_d;
  logic [CW-1:0]           grant_chan_q, grant_chan_d;
  logic [RW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_CHANNELS-1:0] timeout_q, timeout_d;

  logic [NUM_ROUTERS-1:0]  owns;
  logic [NUM_ROUTERS-1:0]  elig;
  logic                    idle_found;
  logic [CW-1:0]           idle_sel;
  logic                    rtr_found;
  logic [RW-1:0]           rtr_sel;
  int                      scan_idx;

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] cur);
    int n;
    n = int'(cur) + 1;
    if (n >= NUM_ROUTERS) n = 0;
    return RW'(n);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= CH_IDLE;
        owner_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      grant_q      <= '0;
      grant_chan_q <= '0;
      rr_ptr_q     <= '0;
      timeout_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      grant_q      <= grant_d;
      grant_chan_q <= grant_chan_d;
      rr_ptr_q     <= rr_ptr_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    grant_chan_d = '0;
    rr_ptr_d     = rr_ptr_q;
    timeout_d    = '0;
    owns         = '0;
    elig         = '0;
    idle_found   = 1'b0;
    idle_sel     = '0;
    rtr_found    = 1'b0;
    rtr_sel      = '0;
    scan_idx     = 0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] == CH_BUSY) owns[owner_q[c]] = 1'b1;
    end

    // Per-channel transitions. done is only looked at in BUSY, so a done
    // from a router that is merely offered has no effect.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        CH_OFFERED: begin
          if (request[owner_q[c]]) begin
            state_d[c] = CH_BUSY;
            cnt_d[c]   = '0;
            rr_ptr_d   = next_ptr(owner_q[c]);
          end else begin
            state_d[c] = CH_IDLE;
            owner_d[c] = '0;
          end
        end
        CH_BUSY: begin
          if (done[owner_q[c]]) begin
            state_d[c] = CH_IDLE;
            owner_d[c] = '0;
            cnt_d[c]   = '0;
          end else if (TIMEOUT_CYCLES > 0 && cnt_q[c] == CNT_LAST) begin
            state_d[c]   = CH_IDLE;
            owner_d[c]   = '0;
            cnt_d[c]     = '0;
            timeout_d[c] = 1'b1;
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // New offer decisions use registered state only, so a channel released
    // on this edge is not offered until the following edge.
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      elig[i] = request[i] & ~owns[i] & ~grant_q[i];
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!idle_found && state_q[c] == CH_IDLE) begin
        idle_found = 1'b1;
        idle_sel   = CW'(c);
      end
    end
    for (int k = 0; k < NUM_ROUTERS; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_ROUTERS) scan_idx = scan_idx - NUM_ROUTERS;
      if (!rtr_found && elig[scan_idx]) begin
        rtr_found = 1'b1;
        rtr_sel   = RW'(scan_idx);
      end
    end
    if (grant_q == '0 && idle_found && rtr_found) begin
      grant_d[rtr_sel]  = 1'b1;
      grant_chan_d      = idle_sel;
      state_d[idle_sel] = CH_OFFERED;
      owner_d[idle_sel] = rtr_sel;
    end
  end

  always_comb begin
    chan_busy  = '0;
    chan_owner = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] == CH_BUSY) begin
        chan_busy[c]            = 1'b1;
        chan_owner[c*RW +: RW]  = owner_q[c];
      end
    end
  end

  assign grant      = grant_q;
  assign grant_chan = grant_chan_q;
  assign timeout    = timeout_q;

endmodule
